// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared state encoding, address/length constants and the
// min helpers used by the chunk-size calculation of dma_xfer_scheduler.
package dma_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } sched_state_t;

    localparam int BOUNDARY_4K = 4096;
    localparam int WORD_BYTES  = 4;

    // Chunk arithmetic is done unsigned at this width, which covers LEN_W+1
    // for any LEN_W up to 63 so the 4 KB distance terms never wrap.
    localparam int CALC_W = 64;
    typedef logic [CALC_W-1:0] calc_t;

    function automatic calc_t min2(input calc_t a, input calc_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic calc_t min3(input calc_t a, input calc_t b, input calc_t c);
        return min2(min2(a, b), c);
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin pick. The first requesting channel
// strictly after i_last wins; the search wraps back to channel 0.
module dma_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Two passes: channels above the pointer first, then the wrap-around
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!o_any && i_req[j] && (j > int'(i_last))) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/dma_xfer_scheduler.sv
// dma_xfer_scheduler: round-robin scheduler that splits each channel's transfer
// into chunks that never cross a 4 KB page on src or dst, drives the read and
// write masters one chunk at a time and pulses per-channel completion.
// Optional WAIT watchdog: define DMA_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request pending
// ARB   | grant one channel, latch its command
// ISSUE | start pulse to both masters, chunk outputs valid
// WAIT  | collect rd/wr done pulses
// NEXT  | advance src/dst, reduce remaining length
// DONE  | completion pulse for the owning channel
module dma_xfer_scheduler #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int MAX_CHUNK   = 1024,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         i_req_valid,
    output logic [NUM_CH-1:0]         o_req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]  i_req_src,
    input  logic [NUM_CH*ADDR_W-1:0]  i_req_dst,
    input  logic [NUM_CH*LEN_W-1:0]   i_req_len,
    output logic                      o_rd_start,
    output logic [ADDR_W-1:0]         o_rd_src_addr,
    output logic [LEN_W-1:0]          o_rd_total_len,
    input  logic                      i_rd_done,
    output logic                      o_wr_start,
    output logic [ADDR_W-1:0]         o_wr_dst_addr,
    output logic [LEN_W-1:0]          o_wr_total_len,
    input  logic                      i_wr_done,
    output logic [NUM_CH-1:0]         o_ch_done,
    output logic [NUM_CH-1:0]         o_ch_err,
    output logic                      o_busy,
    output logic [$clog2(NUM_CH)-1:0] o_cur_ch
);
    import dma_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_CH);

    sched_state_t      r_state, w_state_nx;
    logic [IDX_W-1:0]  r_last, r_cur;
    logic [ADDR_W-1:0] r_src, r_dst, r_rd_addr, r_wr_addr;
    logic [LEN_W-1:0]  r_rem, r_chunk;
    logic              r_rd_seen, r_wr_seen;

    logic [NUM_CH-1:0] w_grant, w_cur_1h;
    logic [IDX_W-1:0]  w_gidx;
    logic              w_gany, w_hs, w_any_valid, w_both_fin, w_timeout;
    logic [ADDR_W-1:0] w_sel_src, w_sel_dst, w_src_nx, w_dst_nx;
    logic [LEN_W-1:0]  w_sel_len, w_rem_nx, w_chunk;
    calc_t             w_bnd_src, w_bnd_dst;

    dma_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .i_req   (i_req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    assign w_any_valid = |i_req_valid;
    assign w_hs        = (r_state == ARB) && w_gany;
    assign w_both_fin  = (r_rd_seen | i_rd_done) & (r_wr_seen | i_wr_done);
    assign w_cur_1h    = NUM_CH'(1) << r_cur;

    // Select the granted channel's command fields
    always_comb begin
        w_sel_src = '0;
        w_sel_dst = '0;
        w_sel_len = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) begin
                w_sel_src = i_req_src[c*ADDR_W +: ADDR_W];
                w_sel_dst = i_req_dst[c*ADDR_W +: ADDR_W];
                w_sel_len = i_req_len[c*LEN_W +: LEN_W];
            end
        end
    end

    // Next src/dst/remaining: latched on grant (word aligned), advanced in NEXT
    always_comb begin
        w_src_nx = r_src;
        w_dst_nx = r_dst;
        w_rem_nx = r_rem;
        if (w_hs) begin
            w_src_nx = w_sel_src & ~ADDR_W'(WORD_BYTES - 1);
            w_dst_nx = w_sel_dst & ~ADDR_W'(WORD_BYTES - 1);
            w_rem_nx = w_sel_len & ~LEN_W'(WORD_BYTES - 1);
        end else if (r_state == NEXT) begin
            w_src_nx = r_src + ADDR_W'(r_chunk);
            w_dst_nx = r_dst + ADDR_W'(r_chunk);
            w_rem_nx = r_rem - r_chunk;
        end
    end

    // Chunk for the upcoming ISSUE, computed from the values it will use
    assign w_bnd_src = calc_t'(BOUNDARY_4K) - calc_t'(w_src_nx[11:0]);
    assign w_bnd_dst = calc_t'(BOUNDARY_4K) - calc_t'(w_dst_nx[11:0]);
    assign w_chunk   = LEN_W'(min3(calc_t'(w_rem_nx), calc_t'(MAX_CHUNK),
                                   min2(w_bnd_src, w_bnd_dst)));

    // Next-state logic; completion has priority over a same-cycle watchdog expiry
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_any_valid) w_state_nx = ARB;
            ARB:     if (w_hs) w_state_nx = (w_rem_nx == '0) ? DONE : ISSUE;
                     else      w_state_nx = IDLE;
            ISSUE:   w_state_nx = WAIT;
            WAIT:    if (w_both_fin)     w_state_nx = NEXT;
                     else if (w_timeout) w_state_nx = w_any_valid ? ARB : IDLE;
            NEXT:    w_state_nx = (w_rem_nx != '0) ? ISSUE : DONE;
            DONE:    w_state_nx = w_any_valid ? ARB : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    // Transfer datapath, RR pointer and chunk outputs loaded on entry to ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_chunk   <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_last    <= IDX_W'(NUM_CH - 1);
            r_cur     <= '0;
        end else begin
            r_src <= w_src_nx;
            r_dst <= w_dst_nx;
            r_rem <= w_rem_nx;
            if (w_hs) begin
                r_last <= w_gidx;
                r_cur  <= w_gidx;
            end
            if (w_state_nx == ISSUE) begin
                r_chunk   <= w_chunk;
                r_rd_addr <= w_src_nx;
                r_wr_addr <= w_dst_nx;
            end
        end
    end

    // Sticky done flags, only listening while in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
        end else if (r_state == WAIT) begin
            if (i_rd_done) r_rd_seen <= 1'b1;
            if (i_wr_done) r_wr_seen <= 1'b1;
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   r_wdog;
    logic [NUM_CH-1:0] r_err;

    assign w_timeout = (r_state == WAIT) && (r_wdog == '0) && !w_both_fin;

    // Watchdog down-counter: armed in ISSUE, terminal count at zero in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          r_wdog <= '0;
        else if (r_state == ISSUE)             r_wdog <= TO_W'(TIMEOUT_CYC - 1);
        else if (r_state == WAIT && r_wdog != '0) r_wdog <= r_wdog - TO_W'(1);
    end

    // One-cycle error pulse for the abandoned channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_err <= '0;
        else          r_err <= w_timeout ? w_cur_1h : '0;
    end

    assign o_ch_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout        = 1'b0;
    assign o_ch_err         = '0;
`endif

    assign o_req_ready    = (r_state == ARB) ? w_grant : '0;
    assign o_rd_start     = (r_state == ISSUE);
    assign o_wr_start     = (r_state == ISSUE);
    assign o_rd_src_addr  = r_rd_addr;
    assign o_wr_dst_addr  = r_wr_addr;
    assign o_rd_total_len = r_chunk;
    assign o_wr_total_len = r_chunk;
    assign o_ch_done      = (r_state == DONE) ? w_cur_1h : '0;
    assign o_busy         = (r_state != IDLE) && (r_state != ARB);
    assign o_cur_ch       = r_cur;

endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// tb_dma_xfer_scheduler: directed stimulus for dma_xfer_scheduler with a
// queue-based scoreboard; a monitor pops expectations on grants, chunk starts,
// completions and errors.
module tb_dma_xfer_scheduler;
    localparam int NUM_CH      = 2;
    localparam int ADDR_W      = 32;
    localparam int LEN_W       = 32;
    localparam int MAX_CHUNK   = 1024;
    localparam int TIMEOUT_CYC = 100;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_CH-1:0]         i_req_valid;
    logic [NUM_CH-1:0]         o_req_ready;
    logic [NUM_CH*ADDR_W-1:0]  i_req_src;
    logic [NUM_CH*ADDR_W-1:0]  i_req_dst;
    logic [NUM_CH*LEN_W-1:0]   i_req_len;
    logic                      o_rd_start, o_wr_start;
    logic [ADDR_W-1:0]         o_rd_src_addr, o_wr_dst_addr;
    logic [LEN_W-1:0]          o_rd_total_len, o_wr_total_len;
    logic                      i_rd_done, i_wr_done;
    logic [NUM_CH-1:0]         o_ch_done, o_ch_err;
    logic                      o_busy;
    logic [$clog2(NUM_CH)-1:0] o_cur_ch;

    dma_xfer_scheduler #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .MAX_CHUNK(MAX_CHUNK), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_src(i_req_src), .i_req_dst(i_req_dst), .i_req_len(i_req_len),
        .o_rd_start(o_rd_start), .o_rd_src_addr(o_rd_src_addr),
        .o_rd_total_len(o_rd_total_len), .i_rd_done(i_rd_done),
        .o_wr_start(o_wr_start), .o_wr_dst_addr(o_wr_dst_addr),
        .o_wr_total_len(o_wr_total_len), .i_wr_done(i_wr_done),
        .o_ch_done(o_ch_done), .o_ch_err(o_ch_err),
        .o_busy(o_busy), .o_cur_ch(o_cur_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } cmd_t;

    typedef struct packed {
        int          ch;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } chunk_t;

    cmd_t   cmd_q0[$];
    cmd_t   cmd_q1[$];
    chunk_t exp_chunk[$];
    int     exp_grant[$];
    int     exp_done[$];
    int     exp_done_lat[$];
    int     exp_err[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_dly = 10;
    int wr_dly = 10;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic push_cmd(input int ch, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l);
        cmd_t c;
        c.src = s; c.dst = d; c.len = l;
        if (ch == 0) cmd_q0.push_back(c);
        else         cmd_q1.push_back(c);
    endtask

    task automatic exp_ck(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l);
        chunk_t e;
        e.ch = ch; e.src = s; e.dst = d; e.len = l;
        exp_chunk.push_back(e);
    endtask

    task automatic exp_dn(input int ch, input int max_lat);
        exp_done.push_back(ch);
        exp_done_lat.push_back(max_lat);
    endtask

    // Request driver: one command per channel presented, popped after handshake
    initial begin
        logic [NUM_CH-1:0] pend;
        pend        = '0;
        i_req_valid = '0;
        i_req_src   = '0;
        i_req_dst   = '0;
        i_req_len   = '0;
        forever begin
            @(negedge clk);
            if (pend[0]) begin void'(cmd_q0.pop_front()); i_req_valid[0] = 1'b0; end
            if (pend[1]) begin void'(cmd_q1.pop_front()); i_req_valid[1] = 1'b0; end
            if (!i_req_valid[0] && cmd_q0.size() > 0) begin
                i_req_valid[0]    = 1'b1;
                i_req_src[31:0]   = cmd_q0[0].src;
                i_req_dst[31:0]   = cmd_q0[0].dst;
                i_req_len[31:0]   = cmd_q0[0].len;
            end
            if (!i_req_valid[1] && cmd_q1.size() > 0) begin
                i_req_valid[1]    = 1'b1;
                i_req_src[63:32]  = cmd_q1[0].src;
                i_req_dst[63:32]  = cmd_q1[0].dst;
                i_req_len[63:32]  = cmd_q1[0].len;
            end
            #1;
            pend = o_req_ready & i_req_valid;
        end
    end

    // Read master model: done pulse rd_dly cycles after start; 0 withholds it
    initial begin
        i_rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_rd_start && rd_dly > 0) begin
                repeat (rd_dly) @(negedge clk);
                i_rd_done = 1'b1;
                @(negedge clk);
                i_rd_done = 1'b0;
            end
        end
    end

    // Write master model
    initial begin
        i_wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_wr_start && wr_dly > 0) begin
                repeat (wr_dly) @(negedge clk);
                i_wr_done = 1'b1;
                @(negedge clk);
                i_wr_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        int                grant_cyc;
        logic [NUM_CH-1:0] ev;
        chunk_t            ec;
        int                e, lat;
        grant_cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (o_req_ready != '0) begin
                checks++;
                if (!$onehot(o_req_ready)) begin
                    errors++;
                    $display("FAIL ready_onehot: got %b required one-hot", o_req_ready);
                end
                checks++;
                if (exp_grant.size() == 0) begin
                    errors++;
                    $display("FAIL grant: got %b required none", o_req_ready);
                end else begin
                    e  = exp_grant.pop_front();
                    ev = NUM_CH'(1) << e;
                    if (o_req_ready != ev) begin
                        errors++;
                        $display("FAIL grant: got %b required %b", o_req_ready, ev);
                    end
                end
                grant_cyc = cyc;
            end
            if (o_rd_start || o_wr_start) begin
                checks++;
                if (exp_chunk.size() == 0) begin
                    errors++;
                    $display("FAIL chunk: got start src=%h dst=%h len=%0d required none",
                             o_rd_src_addr, o_wr_dst_addr, o_rd_total_len);
                end else begin
                    ec = exp_chunk.pop_front();
                    if (!(o_rd_start && o_wr_start && o_busy) || o_rd_src_addr != ec.src ||
                        o_wr_dst_addr != ec.dst || o_rd_total_len != ec.len ||
                        o_wr_total_len != ec.len || int'(o_cur_ch) != ec.ch) begin
                        errors++;
                        $display("FAIL chunk: got st=%b%b busy=%b ch=%0d src=%h dst=%h rl=%0d wl=%0d required ch=%0d src=%h dst=%h len=%0d",
                                 o_rd_start, o_wr_start, o_busy, o_cur_ch, o_rd_src_addr,
                                 o_wr_dst_addr, o_rd_total_len, o_wr_total_len,
                                 ec.ch, ec.src, ec.dst, ec.len);
                    end
                end
            end
            if (o_ch_done != '0) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL ch_done: got %b required none", o_ch_done);
                end else begin
                    e   = exp_done.pop_front();
                    lat = exp_done_lat.pop_front();
                    ev  = NUM_CH'(1) << e;
                    if (o_ch_done != ev || (lat > 0 && (cyc - grant_cyc) > lat)) begin
                        errors++;
                        $display("FAIL ch_done: got %b after %0d cycles required %b within %0d",
                                 o_ch_done, cyc - grant_cyc, ev, lat);
                    end
                end
            end
            if (o_ch_err != '0) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL ch_err: got %b required none", o_ch_err);
                end else begin
                    e  = exp_err.pop_front();
                    ev = NUM_CH'(1) << e;
                    if (o_ch_err != ev) begin
                        errors++;
                        $display("FAIL ch_err: got %b required %b", o_ch_err, ev);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_chunk.size() != 0 || exp_done.size() != 0 || exp_grant.size() != 0 ||
                exp_err.size() != 0 || cmd_q0.size() != 0 || cmd_q1.size() != 0 ||
                o_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, chunks left=%0d dones left=%0d required 0",
                     name, n, exp_chunk.size(), exp_done.size());
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({o_req_ready, o_rd_start, o_wr_start, o_busy, o_cur_ch, o_ch_done, o_ch_err,
             o_rd_src_addr, o_wr_dst_addr, o_rd_total_len, o_wr_total_len} != '0) begin
            errors++;
            $display("FAIL %s: got rdy=%b st=%b%b busy=%b ch=%0d done=%b err=%b src=%h dst=%h len=%0d required all 0",
                     name, o_req_ready, o_rd_start, o_wr_start, o_busy, o_cur_ch,
                     o_ch_done, o_ch_err, o_rd_src_addr, o_wr_dst_addr, o_rd_total_len);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_quiet("reset_held");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_quiet("reset_released");

        // single chunk
        exp_grant.push_back(0);
        exp_ck(0, 32'h0000_1000, 32'h0000_8000, 256);
        exp_dn(0, 0);
        push_cmd(0, 32'h0000_1000, 32'h0000_8000, 256);
        wait_idle("t1_single");

        // src crosses a 4 KB page
        exp_grant.push_back(0);
        exp_ck(0, 32'h0000_0FF0, 32'h0000_2000, 16);
        exp_ck(0, 32'h0000_1000, 32'h0000_2010, 48);
        exp_dn(0, 0);
        push_cmd(0, 32'h0000_0FF0, 32'h0000_2000, 64);
        wait_idle("t2_src_boundary");

        // 8 KB split into MAX_CHUNK pieces
        exp_grant.push_back(1);
        for (int k = 0; k < 8; k++)
            exp_ck(1, 32'h0001_0000 + 32'(k * 1024), 32'h0002_0000 + 32'(k * 1024), 1024);
        exp_dn(1, 0);
        push_cmd(1, 32'h0001_0000, 32'h0002_0000, 32'h2000);
        wait_idle("t3_max_chunk");

        // both channels requesting back to back
        rd_dly = 2; wr_dly = 3;
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_ck(0, 32'h0000_0100, 32'h0000_0900, 16);
        exp_ck(1, 32'h0000_0200, 32'h0000_0A00, 32);
        exp_ck(0, 32'h0000_0300, 32'h0000_0B00, 20);
        exp_ck(1, 32'h0000_0400, 32'h0000_0C00, 40);
        exp_dn(0, 0); exp_dn(1, 0); exp_dn(0, 0); exp_dn(1, 0);
        push_cmd(0, 32'h0000_0100, 32'h0000_0900, 16);
        push_cmd(0, 32'h0000_0300, 32'h0000_0B00, 20);
        push_cmd(1, 32'h0000_0200, 32'h0000_0A00, 32);
        push_cmd(1, 32'h0000_0400, 32'h0000_0C00, 40);
        wait_idle("t4_round_robin");

        // truncated length of zero: completion without any start
        exp_grant.push_back(0);
        exp_dn(0, 3);
        push_cmd(0, 32'h0000_4000, 32'h0000_5000, 3);
        wait_idle("t5_len3");

        // coincident done pulses, dst... src crossing
        rd_dly = 3; wr_dly = 3;
        exp_grant.push_back(1);
        exp_ck(1, 32'h0000_5FF8, 32'h0000_7000, 8);
        exp_ck(1, 32'h0000_6000, 32'h0000_7008, 24);
        exp_dn(1, 0);
        push_cmd(1, 32'h0000_5FF8, 32'h0000_7000, 32);
        wait_idle("t6_coincident");

        // write done 5 cycles ahead of read done, dst crossing
        rd_dly = 7; wr_dly = 2;
        exp_grant.push_back(0);
        exp_ck(0, 32'h0000_1000, 32'h0000_9FC0, 64);
        exp_ck(0, 32'h0000_1040, 32'h0000_A000, 64);
        exp_dn(0, 0);
        push_cmd(0, 32'h0000_1000, 32'h0000_9FC0, 128);
        wait_idle("t6_staggered");

        // dst page limit below MAX_CHUNK, then misaligned addresses and length
        rd_dly = 4; wr_dly = 4;
        exp_grant.push_back(1);
        exp_ck(1, 32'h0000_3000, 32'h0000_5F00, 256);
        exp_ck(1, 32'h0000_3100, 32'h0000_6000, 256);
        exp_dn(1, 0);
        push_cmd(1, 32'h0000_3000, 32'h0000_5F00, 32'h200);
        wait_idle("t7_dst_boundary");

        exp_grant.push_back(0);
        exp_ck(0, 32'h0000_1000, 32'h0000_3000, 8);
        exp_dn(0, 0);
        push_cmd(0, 32'h0000_1003, 32'h0000_3002, 32'h0A);
        wait_idle("t7_misaligned");

`ifdef DMA_SCHED_TIMEOUT_EN
        // read master never answers: error pulse, no completion, then recovery
        rd_dly = 0; wr_dly = 3;
        exp_grant.push_back(1);
        exp_ck(1, 32'h0000_0100, 32'h0000_0200, 64);
        exp_err.push_back(1);
        push_cmd(1, 32'h0000_0100, 32'h0000_0200, 64);
        wait_idle("t8_timeout");
        rd_dly = 5;
        exp_grant.push_back(0);
        exp_ck(0, 32'h0000_0800, 32'h0000_0C00, 32);
        exp_dn(0, 0);
        push_cmd(0, 32'h0000_0800, 32'h0000_0C00, 32);
        wait_idle("t8_recover");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
